// File: rtl/weight_bank_stream.sv
// Multi-bank weight store: runtime-loadable banks streamed in lock-step as one
// packed word per beat, with valid/ready backpressure and a done pulse per run.
module weight_bank_stream #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int NUM_INPUTS = 784,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wen,
  input  logic [CH_W-1:0]          wsel,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     start,
  output logic                     busy,
  output logic [NUM_CH*DATA_W-1:0] o_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic                     o_last,
  output logic                     done
);

  typedef enum logic {IDLE, RUN} state_t;

  // One extra bit so a full-depth run can count past the last address.
  localparam logic [ADDR_W:0] N_IN     = (ADDR_W+1)'(NUM_INPUTS);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_INPUTS - 1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            o_valid_q, o_valid_d;
  logic            o_last_q, o_last_d;
  logic            done_q, done_d;
  logic            issue;
  logic            accept;
  logic [ADDR_W-1:0] raddr;

  assign raddr = cnt_q[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    done_d    = 1'b0;
    accept    = o_valid_q && o_ready;
    issue     = (state_q == RUN) && (cnt_q < N_IN) && (!o_valid_q || o_ready);

    // A new issue refills the output stage; an accept without refill drains it.
    if (issue) begin
      cnt_d     = cnt_q + 1'b1;
      o_valid_d = 1'b1;
      o_last_d  = (cnt_q == LAST_IDX);
    end else if (accept) begin
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept && o_last_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_valid_q <= o_valid_d;
      o_last_q  <= o_last_d;
      done_q    <= done_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_bank
      (* ram_style = "block" *) logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
      logic [DATA_W-1:0] rd_q;

      // Contents survive reset; out-of-range wsel matches no bank.
      always_ff @(posedge clk) begin
        if (wen && (wsel == CH_W'(gi))) begin
          mem[waddr] <= wdata;
        end
      end

      // Read register doubles as the output stage, so it holds while stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_q <= '0;
        end else if (issue) begin
          rd_q <= mem[raddr];
        end
      end

      assign o_data[gi*DATA_W +: DATA_W] = rd_q;
    end
  endgenerate

  assign busy    = (state_q == RUN);
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign done    = done_q;

endmodule

// File: tb/tb_weight_bank_stream.sv
// Bench for weight_bank_stream: scoreboard of expected beats checked by a negedge
// monitor, plus scenario tasks for latency, stalls, collisions, abort and edge cases.
module tb_weight_bank_stream;

  logic        clk;
  logic        rst;

  // Main instance: 4 banks, 8-beat runs.
  logic        wen;
  logic [1:0]  wsel;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        start;
  logic        busy;
  logic [63:0] o_data;
  logic        o_valid;
  logic        o_ready;
  logic        o_last;
  logic        done;

  // Second instance: 5 banks (so wsel can exceed the bank count), single-beat runs.
  logic        wen1;
  logic [2:0]  wsel1;
  logic [3:0]  waddr1;
  logic [15:0] wdata1;
  logic        start1;
  logic        busy1;
  logic [79:0] o_data1;
  logic        o_valid1;
  logic        o_ready1;
  logic        o_last1;
  logic        done1;

  weight_bank_stream #(.NUM_CH(4), .DATA_W(16), .ADDR_W(10), .NUM_INPUTS(8)) dut (
    .clk(clk), .rst(rst), .wen(wen), .wsel(wsel), .waddr(waddr), .wdata(wdata),
    .start(start), .busy(busy), .o_data(o_data), .o_valid(o_valid),
    .o_ready(o_ready), .o_last(o_last), .done(done)
  );

  weight_bank_stream #(.NUM_CH(5), .DATA_W(16), .ADDR_W(4), .NUM_INPUTS(1)) dut1 (
    .clk(clk), .rst(rst), .wen(wen1), .wsel(wsel1), .waddr(waddr1), .wdata(wdata1),
    .start(start1), .busy(busy1), .o_data(o_data1), .o_valid(o_valid1),
    .o_ready(o_ready1), .o_last(o_last1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [15:0] model_mem [4][8];
  int          total = 0;
  int          bad = 0;
  int          beats_seen = 0;
  int          done_cnt = 0;

  function automatic logic [63:0] exp_word(int a);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = model_mem[k][a];
    return w;
  endfunction

  task automatic push_run();
    beat_t b;
    for (int a = 0; a < 8; a++) begin
      b.data = exp_word(a);
      b.last = (a == 7);
      sb.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Scoreboard monitor: every valid beat must match the head; pop on acceptance.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (o_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_beat got=%h last=%b exp=none", o_data, o_last);
        end else begin
          if (o_data !== sb[0].data || o_last !== sb[0].last) begin
            bad++;
            $display("FAIL sb_beat got=%h last=%b exp=%h last=%b",
                     o_data, o_last, sb[0].data, sb[0].last);
          end
          if (o_ready === 1'b1) begin
            sb.delete(0);
            beats_seen++;
          end
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({busy, o_valid, o_last, done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, o_valid, o_last, done});
    end
    total++;
    if (o_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_data got=%h exp=0", o_data);
    end
    total++;
    if ({busy1, o_valid1, done1} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags1 got=%b exp=000", {busy1, o_valid1, done1});
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic load_banks();
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < 8; a++) begin
        @(posedge clk); #1;
        wen = 1'b1;
        wsel = 2'(k);
        waddr = 10'(a);
        wdata = 16'((k << 12) | a);
        model_mem[k][a] = 16'((k << 12) | a);
      end
    end
    @(posedge clk); #1 wen = 1'b0;
  endtask

  task automatic test_stream();
    int cyc;
    int nb;
    int d0;
    d0 = done_cnt;
    o_ready = 1'b1;
    push_run();
    pulse_start();
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_latency1 got busy=%b valid=%b exp busy=1 valid=0", busy, o_valid);
    end
    cyc = 0;
    nb = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        total++;
        if (o_valid !== 1'b1) begin
          bad++;
          $display("FAIL stream_first_beat got valid=%b exp=1", o_valid);
        end
      end
      if (o_valid === 1'b1 && o_ready === 1'b1) begin
        if (nb == 3) begin
          total++;
          if (o_data !== 64'h3003_2003_1003_0003) begin
            bad++;
            $display("FAIL stream_beat3 got=%h exp=3003200310030003", o_data);
          end
        end
        nb++;
      end
    end
    total++;
    if (cyc != 9 || nb != 8) begin
      bad++;
      $display("FAIL stream_throughput got cycles=%0d beats=%0d exp cycles=9 beats=8", cyc, nb);
    end
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (done_cnt - d0 != 1 || sb.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stream_end got dones=%0d left=%0d busy=%b exp 1/0/0",
               done_cnt - d0, sb.size(), busy);
    end
  endtask

  task automatic test_backpressure();
    int i;
    int d0;
    int b0;
    d0 = done_cnt;
    b0 = beats_seen;
    push_run();
    pulse_start();
    i = 0;
    while (done !== 1'b1 && i < 100) begin
      @(posedge clk); #1 o_ready = ((i % 4) == 0) || ((i % 4) == 3);
      i++;
      @(negedge clk);
    end
    o_ready = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (done_cnt - d0 != 1 || beats_seen - b0 != 8 || sb.size() != 0) begin
      bad++;
      $display("FAIL bp_counts got dones=%0d beats=%0d left=%0d exp 1/8/0",
               done_cnt - d0, beats_seen - b0, sb.size());
    end
  endtask

  task automatic test_collision();
    int k;
    int d0;
    d0 = done_cnt;
    o_ready = 1'b1;
    push_run();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    wen = 1'b1; wsel = 2'd2; waddr = 10'd5; wdata = 16'hBEEF;
    model_mem[2][5] = 16'hBEEF;
    @(posedge clk); #1 wen = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    @(posedge clk);
    push_run();
    pulse_start();
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (done_cnt - d0 != 2 || sb.size() != 0) begin
      bad++;
      $display("FAIL collision_runs got dones=%0d left=%0d exp 2/0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_start_ignored();
    int d0;
    int b0;
    int k;
    d0 = done_cnt;
    b0 = beats_seen;
    o_ready = 1'b1;
    push_run();
    pulse_start();
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (done_cnt - d0 != 1 || beats_seen - b0 != 8 || busy !== 1'b0) begin
      bad++;
      $display("FAIL restart_ignored got dones=%0d beats=%0d busy=%b exp 1/8/0",
               done_cnt - d0, beats_seen - b0, busy);
    end
  endtask

  task automatic test_reset_abort();
    int b0;
    int d0;
    int k;
    b0 = beats_seen;
    o_ready = 1'b1;
    push_run();
    pulse_start();
    k = 0;
    while (beats_seen - b0 < 4 && k < 40) begin @(negedge clk); #1; k++; end
    total++;
    if (beats_seen - b0 != 4) begin
      bad++;
      $display("FAIL abort_reach got beats=%0d exp=4", beats_seen - b0);
    end
    @(posedge clk); #1 rst = 1'b1;
    d0 = done_cnt;
    @(posedge clk); @(negedge clk);
    total++;
    if ({o_valid, busy, done, o_last} !== 4'b0000 || o_data !== 64'h0) begin
      bad++;
      $display("FAIL abort_outputs got v/b/d/l=%b data=%h exp 0000/0",
               {o_valid, busy, done, o_last}, o_data);
    end
    rst = 1'b0;
    sb.delete();
    repeat (4) @(posedge clk);
    @(negedge clk); #1;
    total++;
    if (done_cnt != d0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_no_done got dones=%0d valid=%b exp 0/0", done_cnt - d0, o_valid);
    end
    d0 = done_cnt;
    push_run();
    pulse_start();
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    @(posedge clk); @(negedge clk); #1;
    total++;
    if (done_cnt - d0 != 1 || sb.size() != 0) begin
      bad++;
      $display("FAIL abort_rerun got dones=%0d left=%0d exp 1/0", done_cnt - d0, sb.size());
    end
  endtask

  task automatic test_wsel_single();
    logic [79:0] exp1;
    int k;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      wen1 = 1'b1; wsel1 = 3'(c); waddr1 = 4'd0; wdata1 = 16'hA000 + 16'(c);
      exp1[c*16 +: 16] = 16'hA000 + 16'(c);
    end
    for (int c = 5; c < 8; c++) begin
      @(posedge clk); #1;
      wen1 = 1'b1; wsel1 = 3'(c); waddr1 = 4'd0; wdata1 = 16'hDEAD;
    end
    @(posedge clk); #1 wen1 = 1'b0;
    o_ready1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    k = 0;
    @(negedge clk);
    while (o_valid1 !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    total++;
    if (o_valid1 !== 1'b1 || o_data1 !== exp1) begin
      bad++;
      $display("FAIL single_beat got valid=%b data=%h exp valid=1 data=%h", o_valid1, o_data1, exp1);
    end
    total++;
    if (o_last1 !== 1'b1) begin
      bad++;
      $display("FAIL single_last got=%b exp=1", o_last1);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({done1, o_valid1, busy1} !== 3'b100) begin
      bad++;
      $display("FAIL single_done got d/v/b=%b exp=100", {done1, o_valid1, busy1});
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (done1 !== 1'b0) begin
      bad++;
      $display("FAIL single_done_pulse got=%b exp=0", done1);
    end
  endtask

  initial begin
    rst = 1'b1;
    wen = 1'b0; wsel = '0; waddr = '0; wdata = '0; start = 1'b0; o_ready = 1'b1;
    wen1 = 1'b0; wsel1 = '0; waddr1 = '0; wdata1 = '0; start1 = 1'b0; o_ready1 = 1'b1;
    test_reset();
    load_banks();
    test_stream();
    test_backpressure();
    test_collision();
    test_start_ignored();
    test_reset_abort();
    test_wsel_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
